// File: rtl/inst_queue_pkg.sv
// Shared types for the decode -> dispatch instruction queue: the PC_set
// record, the default queue depth and a wrapping pointer helper.
package inst_queue_pkg;

    typedef struct packed {
        logic        o_valid;
        logic [31:0] PC;
        logic [31:0] inst;
    } PC_set;

    localparam int IQ_DEPTH = 8;

    // Pointer plus n, wrapped modulo a power-of-two depth.
    function automatic int unsigned iq_inc(input int unsigned ptr,
                                           input int unsigned n,
                                           input int unsigned depth);
        return (ptr + n) & (depth - 1);
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Decode/dispatch side of the instruction queue: two push slots, two head
// slots, the consume count and occupancy. master = queue, slave = pipeline.
interface inst_queue_if
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) ();

    // Handshake: decode may present i_set1/i_set2 (each qualified by its own
    // o_valid) every cycle; they are taken at the clock edge only when o_ready
    // was high, otherwise decode holds them. Dispatch reports in i_usingNUM how
    // many of the valid o_set1/o_set2 entries it consumed at that same edge.
    PC_set                  i_set1;
    PC_set                  i_set2;
    logic                   o_ready;
    PC_set                  o_set1;
    PC_set                  o_set2;
    logic [1:0]             i_usingNUM;
    logic [$clog2(DEPTH):0] o_count;

    modport master (
        input  i_set1, i_set2, i_usingNUM,
        output o_ready, o_set1, o_set2, o_count
    );

    modport slave (
        output i_set1, i_set2, i_usingNUM,
        input  o_ready, o_set1, o_set2, o_count
    );

endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue: takes up to two decoded entries per cycle and
// exposes the two oldest to dispatch, retiring 0/1/2 per cycle.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    inst_queue_if.master bus
);

    PC_set            mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic [1:0]       avail_n;
    logic             ready;
    logic             wr0_en;
    logic             wr1_en;
    PC_set            wr0_data;
    PC_set            wr1_data;
    PC_set            set1_out;
    PC_set            set2_out;

    always_comb begin
        head_p1  = PTR_W'(iq_inc(32'(head), 32'd1, 32'(DEPTH)));
        tail_p1  = PTR_W'(iq_inc(32'(tail), 32'd1, 32'(DEPTH)));
        // Registered count only: pops this cycle free slots next cycle.
        ready    = (count <= (PTR_W+1)'(DEPTH - 2));
        avail_n  = (count >= 2) ? 2'd2 : ((count == 0) ? 2'd0 : 2'd1);
        pop_n    = (bus.i_usingNUM > avail_n) ? avail_n : bus.i_usingNUM;

        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = bus.i_set1;
        wr1_data = bus.i_set2;
        push_n   = 2'd0;
        if (ready) begin
            // A lone set2 is compacted into the tail slot.
            unique case ({bus.i_set1.o_valid, bus.i_set2.o_valid})
                2'b11: begin
                    wr0_en = 1'b1;
                    wr1_en = 1'b1;
                    push_n = 2'd2;
                end
                2'b10: begin
                    wr0_en = 1'b1;
                    push_n = 2'd1;
                end
                2'b01: begin
                    wr0_en   = 1'b1;
                    wr0_data = bus.i_set2;
                    push_n   = 2'd1;
                end
                default: ;
            endcase
        end

        count_next = count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);

        set1_out         = mem[head];
        set1_out.o_valid = (avail_n != 2'd0);
        set2_out         = mem[head_p1];
        set2_out.o_valid = (avail_n == 2'd2);
    end

    assign bus.o_set1  = set1_out;
    assign bus.o_set2  = set2_out;
    assign bus.o_ready = ready;
    assign bus.o_count = count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= PTR_W'(iq_inc(32'(head), 32'(pop_n), 32'(DEPTH)));
            tail  <= PTR_W'(iq_inc(32'(tail), 32'(push_n), 32'(DEPTH)));
            count <= count_next;
        end
    end

    // Entry contents carry no reset; a dropped push never lands.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (wr0_en) mem[tail]    <= wr0_data;
            if (wr1_en) mem[tail_p1] <= wr1_data;
        end
    end

`ifndef SYNTHESIS
    // Dispatch must never consume more entries than are presented valid.
    int unsigned illegal_usingnum_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_usingnum_cnt <= 0;
        end else if (!flush) begin
            usingnum_legal: assert (bus.i_usingNUM <= avail_n) else begin
                illegal_usingnum_cnt <= illegal_usingnum_cnt + 1;
                $warning("inst_queue: i_usingNUM=%0d with only %0d valid outputs",
                         bus.i_usingNUM, avail_n);
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, push/pop, full, wrap, flush and
// clamping, each scenario checked against hand-computed values.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   tests = 0;
    int   fails = 0;

    inst_queue_if #(.DEPTH(8)) bus ();

    inst_queue #(.DEPTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "tb_inst_queue timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [31:0] pc1,
                         input logic v2, input logic [31:0] pc2,
                         input logic [1:0] use_n);
        bus.i_set1     = '{o_valid: v1, PC: pc1, inst: ~pc1};
        bus.i_set2     = '{o_valid: v2, PC: pc2, inst: ~pc2};
        bus.i_usingNUM = use_n;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 2'd0);
    endtask

    task automatic push_pair(input logic [31:0] pc1, input logic [31:0] pc2);
        drive(1'b1, pc1, 1'b1, pc2, 2'd0);
        tick();
        idle();
    endtask

    task automatic pop(input logic [1:0] n);
        drive(1'b0, 32'h0, 1'b0, 32'h0, n);
        tick();
        idle();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++; if (bus.o_set1.o_valid !== 1'b0) begin fails++; $display("FAIL rst_v1 got=%b exp=0", bus.o_set1.o_valid); end
        tests++; if (bus.o_set2.o_valid !== 1'b0) begin fails++; $display("FAIL rst_v2 got=%b exp=0", bus.o_set2.o_valid); end
        tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL rst_count got=%0d exp=0", bus.o_count); end
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", bus.o_ready); end
        push_pair(32'h1c000000, 32'h1c000004);
        tests++; if (bus.o_set1.PC !== 32'h1c000000) begin fails++; $display("FAIL first_pc1 got=%h exp=1c000000", bus.o_set1.PC); end
        tests++; if (bus.o_set2.PC !== 32'h1c000004) begin fails++; $display("FAIL first_pc2 got=%h exp=1c000004", bus.o_set2.PC); end
        tests++; if ({bus.o_set1.o_valid, bus.o_set2.o_valid} !== 2'b11) begin fails++; $display("FAIL first_valid got=%b exp=11", {bus.o_set1.o_valid, bus.o_set2.o_valid}); end
        tests++; if (bus.o_count !== 4'd2) begin fails++; $display("FAIL first_count got=%0d exp=2", bus.o_count); end
    endtask

    task automatic test_pop();
        do_flush();
        push_pair(32'h0000a000, 32'h0000b000);
        drive(1'b1, 32'h0000c000, 1'b0, 32'h0, 2'd0);
        tick();
        idle();
        tests++; if (bus.o_count !== 4'd3) begin fails++; $display("FAIL pop_start_count got=%0d exp=3", bus.o_count); end
        pop(2'd1);
        tests++; if (bus.o_set1.PC !== 32'h0000b000) begin fails++; $display("FAIL pop1_pc1 got=%h exp=0000b000", bus.o_set1.PC); end
        tests++; if (bus.o_set2.PC !== 32'h0000c000) begin fails++; $display("FAIL pop1_pc2 got=%h exp=0000c000", bus.o_set2.PC); end
        tests++; if (bus.o_count !== 4'd2) begin fails++; $display("FAIL pop1_count got=%0d exp=2", bus.o_count); end
        pop(2'd2);
        tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL pop2_count got=%0d exp=0", bus.o_count); end
        tests++; if ({bus.o_set1.o_valid, bus.o_set2.o_valid} !== 2'b00) begin fails++; $display("FAIL pop2_valid got=%b exp=00", {bus.o_set1.o_valid, bus.o_set2.o_valid}); end
    endtask

    task automatic test_fill();
        logic [31:0] base;
        base = 32'h1c000100;
        do_flush();
        for (int k = 0; k < 3; k++) begin
            push_pair(base + 32'(8 * k), base + 32'(8 * k + 4));
        end
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL fill6_ready got=%b exp=1", bus.o_ready); end
        drive(1'b1, base + 32'd24, 1'b0, 32'h0, 2'd0);
        tick();
        idle();
        tests++; if (bus.o_count !== 4'd7) begin fails++; $display("FAIL fill7_count got=%0d exp=7", bus.o_count); end
        tests++; if (bus.o_ready !== 1'b0) begin fails++; $display("FAIL fill7_ready got=%b exp=0", bus.o_ready); end
        drive(1'b1, 32'hdead0000, 1'b1, 32'hdead0004, 2'd0);
        tick();
        idle();
        tests++; if (bus.o_count !== 4'd7) begin fails++; $display("FAIL fill7_hold_count got=%0d exp=7", bus.o_count); end
        pop(2'd1);
        tests++; if (bus.o_count !== 4'd6) begin fails++; $display("FAIL fill_pop1_count got=%0d exp=6", bus.o_count); end
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL fill_pop1_ready got=%b exp=1", bus.o_ready); end
        tests++; if (bus.o_set1.PC !== base + 32'd4) begin fails++; $display("FAIL fill_pop1_pc1 got=%h exp=%h", bus.o_set1.PC, base + 32'd4); end
        push_pair(base + 32'd28, base + 32'd32);
        tests++; if (bus.o_count !== 4'd8) begin fails++; $display("FAIL fill8_count got=%0d exp=8", bus.o_count); end
        tests++; if (bus.o_ready !== 1'b0) begin fails++; $display("FAIL fill8_ready got=%b exp=0", bus.o_ready); end
        drive(1'b1, 32'hdead0008, 1'b1, 32'hdead000c, 2'd0);
        tick();
        idle();
        tests++; if (bus.o_count !== 4'd8) begin fails++; $display("FAIL fill8_hold_count got=%0d exp=8", bus.o_count); end
        pop(2'd2);
        tests++; if (bus.o_count !== 4'd6) begin fails++; $display("FAIL fill_pop2_count got=%0d exp=6", bus.o_count); end
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL fill_pop2_ready got=%b exp=1", bus.o_ready); end
        tests++; if (bus.o_set1.PC !== base + 32'd12) begin fails++; $display("FAIL fill_pop2_pc1 got=%h exp=%h", bus.o_set1.PC, base + 32'd12); end
        tests++; if (bus.o_set2.PC !== base + 32'd16) begin fails++; $display("FAIL fill_pop2_pc2 got=%h exp=%h", bus.o_set2.PC, base + 32'd16); end
    endtask

    // Continues from test_fill: head=3, six entries base+12..base+32.
    task automatic test_wrap();
        logic [31:0] base;
        base = 32'h1c000100;
        pop(2'd2);
        pop(2'd2);
        tests++; if (bus.o_set1.PC !== base + 32'd28) begin fails++; $display("FAIL wrap_rd_pc1 got=%h exp=%h", bus.o_set1.PC, base + 32'd28); end
        tests++; if (bus.o_set2.PC !== base + 32'd32) begin fails++; $display("FAIL wrap_rd_pc2 got=%h exp=%h", bus.o_set2.PC, base + 32'd32); end
        tests++; if (bus.o_count !== 4'd2) begin fails++; $display("FAIL wrap_rd_count got=%0d exp=2", bus.o_count); end
        pop(2'd2);
        for (int k = 0; k < 3; k++) begin
            push_pair(32'h00e00000 + 32'(8 * k), 32'h00e00004 + 32'(8 * k));
        end
        tests++; if (bus.o_set1.PC !== 32'h00e00000) begin fails++; $display("FAIL wrap_head1_pc1 got=%h exp=00e00000", bus.o_set1.PC); end
        pop(2'd2);
        pop(2'd2);
        pop(2'd2);
        push_pair(32'h00f00000, 32'h00f00004);
        tests++; if (dut.mem[7].PC !== 32'h00f00000) begin fails++; $display("FAIL wrap_slot7 got=%h exp=00f00000", dut.mem[7].PC); end
        tests++; if (dut.mem[0].PC !== 32'h00f00004) begin fails++; $display("FAIL wrap_slot0 got=%h exp=00f00004", dut.mem[0].PC); end
        tests++; if (bus.o_set2.PC !== 32'h00f00004) begin fails++; $display("FAIL wrap_wr_pc2 got=%h exp=00f00004", bus.o_set2.PC); end
        pop(2'd1);
        tests++; if (bus.o_set1.PC !== 32'h00f00004) begin fails++; $display("FAIL wrap_pop1_pc1 got=%h exp=00f00004", bus.o_set1.PC); end
        tests++; if ({bus.o_set1.o_valid, bus.o_set2.o_valid} !== 2'b10) begin fails++; $display("FAIL wrap_pop1_valid got=%b exp=10", {bus.o_set1.o_valid, bus.o_set2.o_valid}); end
    endtask

    task automatic test_push_pop_flush();
        do_flush();
        push_pair(32'h00a00000, 32'h00a00004);
        push_pair(32'h00a00008, 32'h00a0000c);
        drive(1'b1, 32'h00a00010, 1'b1, 32'h00a00014, 2'd2);
        tick();
        idle();
        tests++; if (bus.o_count !== 4'd4) begin fails++; $display("FAIL pp_count got=%0d exp=4", bus.o_count); end
        tests++; if (bus.o_set1.PC !== 32'h00a00008) begin fails++; $display("FAIL pp_pc1 got=%h exp=00a00008", bus.o_set1.PC); end
        flush = 1'b1;
        drive(1'b1, 32'h00b00000, 1'b1, 32'h00b00004, 2'd2);
        tick();
        flush = 1'b0;
        idle();
        tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL ppf_count got=%0d exp=0", bus.o_count); end
        tests++; if ({bus.o_set1.o_valid, bus.o_set2.o_valid} !== 2'b00) begin fails++; $display("FAIL ppf_valid got=%b exp=00", {bus.o_set1.o_valid, bus.o_set2.o_valid}); end
        tests++; if (bus.o_ready !== 1'b1) begin fails++; $display("FAIL ppf_ready got=%b exp=1", bus.o_ready); end
        push_pair(32'h00c00000, 32'h00c00004);
        tests++; if (bus.o_set1.PC !== 32'h00c00000) begin fails++; $display("FAIL ppf_after_pc1 got=%h exp=00c00000", bus.o_set1.PC); end
        tests++; if (dut.head !== 3'd0) begin fails++; $display("FAIL ppf_after_head got=%0d exp=0", dut.head); end
    endtask

    task automatic test_set2_only();
        int unsigned cnt0;
        do_flush();
        drive(1'b0, 32'h0, 1'b1, 32'h1c000010, 2'd0);
        tick();
        idle();
        tests++; if (bus.o_set1.PC !== 32'h1c000010) begin fails++; $display("FAIL s2_pc1 got=%h exp=1c000010", bus.o_set1.PC); end
        tests++; if ({bus.o_set1.o_valid, bus.o_set2.o_valid} !== 2'b10) begin fails++; $display("FAIL s2_valid got=%b exp=10", {bus.o_set1.o_valid, bus.o_set2.o_valid}); end
        tests++; if (bus.o_count !== 4'd1) begin fails++; $display("FAIL s2_count got=%0d exp=1", bus.o_count); end
        cnt0 = dut.illegal_usingnum_cnt;
        pop(2'd2);
        tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL clamp_count got=%0d exp=0", bus.o_count); end
        tests++; if (dut.illegal_usingnum_cnt !== cnt0 + 1) begin fails++; $display("FAIL clamp_assert got=%0d exp=%0d", dut.illegal_usingnum_cnt, cnt0 + 1); end
        pop(2'd0);
        tests++; if (bus.o_count !== 4'd0) begin fails++; $display("FAIL empty_idle_count got=%0d exp=0", bus.o_count); end
    endtask

    initial begin
        test_reset();
        test_pop();
        test_fill();
        test_wrap();
        test_push_pop_flush();
        test_set2_only();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Decoded-instruction FIFO between the decode stage and Issue_dispatch.
- Accepts up to two PC_set entries per cycle from decode.
- Presents the two oldest entries as o_set1/o_set2 to the dispatcher.
- Retires 0/1/2 entries per cycle according to the dispatcher's usingNUM count; this is the producer end of the set1/set2/usingNUM interface.

Parameters:
- DEPTH, 8: number of PC_set entries. Must be a power of two and at least 4.
- PTR_W, $clog2(DEPTH): width of the head/tail pointers.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush (branch mispredict/exception); empties the queue.
- i_set1  input  PC_set  older decoded instruction; i_set1.o_valid qualifies it.
- i_set2  input  PC_set  younger decoded instruction; i_set2.o_valid qualifies it.
- o_ready  output  1  queue can accept two entries this cycle; decode must hold when low.
- o_set1  output  PC_set  head entry to dispatch.
- o_set2  output  PC_set  head+1 entry to dispatch.
- i_usingNUM  input  2  entries consumed by dispatch this cycle (0, 1 or 2).
- o_count  output  PTR_W+1  current occupancy.

Behaviour:
- **Storage:** circular buffer of DEPTH PC_set registers.
  - head, tail: PTR_W bits, wrap modulo DEPTH naturally.
  - count: PTR_W+1 bits, range 0..DEPTH.
- **Reset (rst=1 at posedge):** head=0, tail=0, count=0.
  - Outputs in the cycle after reset: o_set1.o_valid=0, o_set2.o_valid=0, o_count=0, o_ready=1.
  - Entry contents are not reset.
- **o_ready:** equals (DEPTH - count) >= 2, computed from registered count only. There is no combinational path from i_usingNUM or flush to o_ready.
- **Push (when o_ready=1):**
  - push_n = number of valid inputs.
  - Inputs are compacted:
    - both valid: set1 is written at tail, set2 at tail+1.
    - only set1 valid: set1 is written at tail.
    - only set2 valid: set2 is written at tail.
  - tail advances by push_n.
  - Inputs presented while o_ready=0 are ignored; decode is responsible for holding them.
- **Read:**
  - o_set1 = entry[head], o_set2 = entry[head+1] (wraps), read combinationally from registered storage.
  - o_set1.o_valid = (count>=1); o_set2.o_valid = (count>=2). The stored o_valid bit is overridden.
  - The pattern set1 invalid / set2 valid is never presented.
  - There is no bypass: a pushed entry becomes visible on the cycle after the push edge (latency 1).
- **Pop:**
  - pop_n = min(i_usingNUM, number of valid outputs).
  - head advances by pop_n.
  - i_usingNUM=3, or i_usingNUM exceeding the valid outputs, is illegal. Simulation assertion fires; RTL clamps.
- **Simultaneous push and pop:** count_next = count + push_n - pop_n. Pop frees slots only for the next cycle's o_ready.
- **Full/empty:**
  - count==DEPTH: o_ready=0.
  - count==DEPTH-1: o_ready=0 even if only one input is valid; the decoder always pairs.
  - count==0: both output valids are 0 and any i_usingNUM is clamped to 0.
- **Flush (synchronous):**
  - At the edge: head=tail=count=0, same as reset.
  - Flush dominates push and pop in the same cycle; inputs that cycle are dropped.
- **Reset/flush mid-operation:** any in-flight push or pop that cycle is discarded.
- **Pointer wrap:** head+1 and tail+1 wrap from DEPTH-1 to 0. A two-entry push or pop that straddles the wrap is legal.

Decomposition:
- **Public_Info package:**
  - PC_set (existing).
  - New constant IQ_DEPTH = 8, used by the integrating top.
  - Helper function iq_inc(ptr, n), giving pointer plus n with wrap.
- **Sub-module:** none; storage, pointers and count fit in one module.
- **Assertion:** the usingNUM legality check lives in a bind-able SVA block inside the module, excluded from synthesis.

Test Plan:
- **Reset then push pair:** rst=1 for 2 cycles, then push PC=0x1c000000 and 0x1c000004 with i_usingNUM=0.
  - Next cycle: o_set1.PC=0x1c000000, o_set2.PC=0x1c000004, both valid, o_count=2.
- **Single and partial pop:** from count=3 (PCs A, B, C), i_usingNUM=1.
  - Next cycle: o_set1=B, o_set2=C, o_count=2.
  - Then i_usingNUM=2: count=0, both o_valid=0.
- **Fill to full:** push pairs with no pops until count=8.
  - o_ready=0 at count=7 and at count=8; a further held push is ignored and count stays 8.
  - One cycle with i_usingNUM=2: count=6 and o_ready=1 next cycle.
- **Wrap-around:** with head=7 and count=2, entries at slots 7 and 0 are presented in order; pop 2 gives head=1.
  - Push a pair with tail=7: the entries land in slots 7 and 0.
- **Simultaneous push/pop with flush:**
  - count=4, push 2, pop 2 at once: count=4, and the head advances by 2.
  - Same stimulus with flush=1: count=0, both o_valid=0, o_ready=1.
- **set2-only push and clamp:**
  - Push only i_set2 (PC=0x1c000010) into an empty queue: it appears as o_set1, and o_set2.o_valid=0.
  - i_usingNUM=2 with count=1: count=0 and the assertion fires.
